// File: rtl/charger_reg_file_pkg.sv
// Shared register-map definitions for the charger control/status register bank.
package charger_reg_file_pkg;

  // Word index within the 64-byte window (byte offset = index * 4).
  typedef enum logic [3:0] {
    IDX_CTRL     = 4'h0,
    IDX_ISET     = 4'h1,
    IDX_VSET     = 4'h2,
    IDX_STATUS   = 4'h3,
    IDX_IRQ_STAT = 4'h4,
    IDX_IRQ_EN   = 4'h5,
    IDX_ADC_V    = 4'h6,
    IDX_ADC_I    = 4'h7,
    IDX_SESSIONS = 4'h8,
    IDX_SCRATCH  = 4'h9
  } reg_idx_e;

  localparam int unsigned IRQ_FAULT = 0;
  localparam int unsigned IRQ_FULL  = 1;
  localparam int unsigned IRQ_OVP   = 2;
  localparam int unsigned IRQ_W     = 3;

  localparam int unsigned CTRL_EN       = 0;
  localparam int unsigned CTRL_STAT_CLR = 1;
  localparam int unsigned CTRL_MODE_LSB = 2;

  function automatic logic [7:0] reg_offset(reg_idx_e idx);
    return {2'b00, idx, 2'b00};
  endfunction

endpackage

// File: rtl/charger_reg_file_if.sv
// Simple register-bus interface between the AXI-Lite bridge and register banks.
interface charger_reg_file_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              reg_en;
  logic              reg_we;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_din;
  logic [DATA_W-1:0] reg_dout;

  modport master (output reg_en, reg_we, reg_addr, reg_din, input reg_dout);
  modport slave  (input reg_en, reg_we, reg_addr, reg_din, output reg_dout);
endinterface

// File: rtl/charger_event_det.sv
// Rising-edge detection of charger status levels plus over-voltage compare.
module charger_event_det #(
  parameter int unsigned ADC_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             chg_active,
  input  logic             chg_fault,
  input  logic             chg_full,
  input  logic             adc_valid,
  input  logic [ADC_W-1:0] adc_v,
  input  logic [ADC_W-1:0] vset_lo,
  output logic             active_rise,
  output logic             fault_rise,
  output logic             full_rise,
  output logic             ovp
);

  logic active_prev;
  logic fault_prev;
  logic full_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_prev <= 1'b0;
      fault_prev  <= 1'b0;
      full_prev   <= 1'b0;
    end else begin
      active_prev <= chg_active;
      fault_prev  <= chg_fault;
      full_prev   <= chg_full;
    end
  end

  // Pulses are combinational so events land in the register bank at the first sampling edge.
  always_comb begin
    active_rise = chg_active & ~active_prev;
    fault_rise  = chg_fault & ~fault_prev;
    full_rise   = chg_full & ~full_prev;
    ovp         = adc_valid && (adc_v > vset_lo);
  end

endmodule

// File: rtl/charger_reg_file.sv
// Charger control/status register bank: decode, storage, read mux and level IRQ.
module charger_reg_file
  import charger_reg_file_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADC_W  = 12
) (
  input  logic               reg_clk,
  input  logic               reg_rst,
  charger_reg_file_if.slave  bus,
  input  logic               chg_active,
  input  logic               chg_fault,
  input  logic               chg_full,
  input  logic               adc_valid,
  input  logic [ADC_W-1:0]   adc_v,
  input  logic [ADC_W-1:0]   adc_i,
  output logic               charge_en,
  output logic [1:0]         chg_mode,
  output logic [15:0]        iset,
  output logic [15:0]        vset,
  output logic               irq
);

  logic              mapped;
  logic [3:0]        off;
  logic              wr;
  logic              rd;
  logic              wr_ctrl;
  logic              wr_iset;
  logic              wr_vset;
  logic              wr_irq_stat;
  logic              wr_irq_en;
  logic              wr_scratch;
  logic              stat_clr;
  logic [IRQ_W-1:0]  irq_stat;
  logic [IRQ_W-1:0]  irq_en;
  logic [IRQ_W-1:0]  irq_set;
  logic [IRQ_W-1:0]  irq_w1c;
  logic [ADC_W-1:0]  adc_v_q;
  logic [ADC_W-1:0]  adc_i_q;
  logic [31:0]       sessions;
  logic [DATA_W-1:0] scratch;
  logic [DATA_W-1:0] rdata;
  logic              active_rise;
  logic              fault_rise;
  logic              full_rise;
  logic              ovp;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^bus.reg_addr[1:0];

  assign mapped = (bus.reg_addr[ADDR_W-1:6] == '0);
  assign off    = bus.reg_addr[5:2];
  assign wr     = bus.reg_en & bus.reg_we & mapped;
  assign rd     = bus.reg_en & ~bus.reg_we;

  charger_event_det #(
    .ADC_W (ADC_W)
  ) u_event_det (
    .clk         (reg_clk),
    .rst         (reg_rst),
    .chg_active  (chg_active),
    .chg_fault   (chg_fault),
    .chg_full    (chg_full),
    .adc_valid   (adc_valid),
    .adc_v       (adc_v),
    .vset_lo     (vset[ADC_W-1:0]),
    .active_rise (active_rise),
    .fault_rise  (fault_rise),
    .full_rise   (full_rise),
    .ovp         (ovp)
  );

  always_comb begin
    wr_ctrl     = wr && (off == IDX_CTRL);
    wr_iset     = wr && (off == IDX_ISET);
    wr_vset     = wr && (off == IDX_VSET);
    wr_irq_stat = wr && (off == IDX_IRQ_STAT);
    wr_irq_en   = wr && (off == IDX_IRQ_EN);
    wr_scratch  = wr && (off == IDX_SCRATCH);
    stat_clr    = wr_ctrl && bus.reg_din[CTRL_STAT_CLR];
    irq_set            = '0;
    irq_set[IRQ_FAULT] = fault_rise;
    irq_set[IRQ_FULL]  = full_rise;
    irq_set[IRQ_OVP]   = ovp;
    irq_w1c = wr_irq_stat ? bus.reg_din[IRQ_W-1:0] : '0;
  end

  always_comb begin
    rdata = '0;
    if (mapped) begin
      case (off)
        IDX_CTRL: begin
          rdata[CTRL_EN]             = charge_en;
          rdata[CTRL_MODE_LSB +: 2]  = chg_mode;
        end
        IDX_ISET:     rdata[15:0]        = iset;
        IDX_VSET:     rdata[15:0]        = vset;
        IDX_STATUS:   rdata[2:0]         = {chg_full, chg_fault, chg_active};
        IDX_IRQ_STAT: rdata[IRQ_W-1:0]   = irq_stat;
        IDX_IRQ_EN:   rdata[IRQ_W-1:0]   = irq_en;
        IDX_ADC_V:    rdata[ADC_W-1:0]   = adc_v_q;
        IDX_ADC_I:    rdata[ADC_W-1:0]   = adc_i_q;
        IDX_SESSIONS: rdata[31:0]        = sessions;
        IDX_SCRATCH:  rdata              = scratch;
        default:      rdata              = '0;
      endcase
    end
  end

  always_ff @(posedge reg_clk or posedge reg_rst) begin
    if (reg_rst) begin
      charge_en    <= 1'b0;
      chg_mode     <= '0;
      iset         <= '0;
      vset         <= '0;
      irq_stat     <= '0;
      irq_en       <= '0;
      adc_v_q      <= '0;
      adc_i_q      <= '0;
      sessions     <= '0;
      scratch      <= '0;
      irq          <= 1'b0;
      bus.reg_dout <= '0;
    end else begin
      if (wr_ctrl) begin
        charge_en <= bus.reg_din[CTRL_EN];
        chg_mode  <= bus.reg_din[CTRL_MODE_LSB +: 2];
      end
      if (wr_iset)    iset    <= bus.reg_din[15:0];
      if (wr_vset)    vset    <= bus.reg_din[15:0];
      if (wr_irq_en)  irq_en  <= bus.reg_din[IRQ_W-1:0];
      if (wr_scratch) scratch <= bus.reg_din;
      if (adc_valid) begin
        adc_v_q <= adc_v;
        adc_i_q <= adc_i;
      end
      // Set is OR-ed after the clear so a coincident event keeps its bit.
      irq_stat <= (irq_stat & ~irq_w1c) | irq_set;
      if (stat_clr)
        sessions <= '0;
      else if (active_rise && (sessions != '1))
        sessions <= sessions + 32'd1;
      irq <= |(irq_stat & irq_en);
      if (rd) bus.reg_dout <= rdata;
    end
  end

endmodule

// File: tb/tb_charger_reg_file.sv
// Directed table-driven bench for the charger register bank.
module tb_charger_reg_file;
  import charger_reg_file_pkg::*;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] din;
    bit          chk;
    logic [31:0] exp;
  } vec_t;

  localparam int unsigned NVEC = 23;

  logic        reg_clk = 1'b0;
  logic        reg_rst = 1'b1;
  logic        chg_active = 1'b0;
  logic        chg_fault = 1'b0;
  logic        chg_full = 1'b0;
  logic        adc_valid = 1'b0;
  logic [11:0] adc_v = '0;
  logic [11:0] adc_i = '0;
  logic        charge_en;
  logic [1:0]  chg_mode;
  logic [15:0] iset;
  logic [15:0] vset;
  logic        irq;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  vec_t        tbl [NVEC];

  charger_reg_file_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  charger_reg_file #(.ADDR_W(32), .DATA_W(32), .ADC_W(12)) dut (
    .reg_clk    (reg_clk),
    .reg_rst    (reg_rst),
    .bus        (bus),
    .chg_active (chg_active),
    .chg_fault  (chg_fault),
    .chg_full   (chg_full),
    .adc_valid  (adc_valid),
    .adc_v      (adc_v),
    .adc_i      (adc_i),
    .charge_en  (charge_en),
    .chg_mode   (chg_mode),
    .iset       (iset),
    .vset       (vset),
    .irq        (irq)
  );

  always #5 reg_clk = ~reg_clk;

  function automatic logic [31:0] ra(reg_idx_e idx);
    return 32'(reg_offset(idx));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] din);
    bus.reg_en   = 1'b1;
    bus.reg_we   = we;
    bus.reg_addr = addr;
    bus.reg_din  = din;
    @(negedge reg_clk);
    bus.reg_en   = 1'b0;
    bus.reg_we   = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] din);
    access(1'b1, addr, din);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    access(1'b0, addr, 32'h0);
    check(name, bus.reg_dout, exp);
  endtask

  initial begin
    tbl[0]  = '{1'b0, ra(IDX_CTRL),     32'h0,         1'b1, 32'h0000_0000};
    tbl[1]  = '{1'b1, ra(IDX_ISET),     32'h0000_1234, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, ra(IDX_ISET),     32'h0,         1'b1, 32'h0000_1234};
    tbl[3]  = '{1'b1, ra(IDX_CTRL),     32'h0000_000F, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, ra(IDX_CTRL),     32'h0,         1'b1, 32'h0000_000D};
    tbl[5]  = '{1'b1, ra(IDX_VSET),     32'hABCD_0800, 1'b0, 32'h0};
    tbl[6]  = '{1'b0, ra(IDX_VSET),     32'h0,         1'b1, 32'h0000_0800};
    tbl[7]  = '{1'b1, ra(IDX_SCRATCH),  32'hDEAD_BEEF, 1'b1, 32'h0000_0800};
    tbl[8]  = '{1'b0, ra(IDX_SCRATCH),  32'h0,         1'b1, 32'hDEAD_BEEF};
    tbl[9]  = '{1'b0, 32'h0000_0027,    32'h0,         1'b1, 32'hDEAD_BEEF};
    tbl[10] = '{1'b1, ra(IDX_IRQ_EN),   32'hFFFF_FFFF, 1'b0, 32'h0};
    tbl[11] = '{1'b0, ra(IDX_IRQ_EN),   32'h0,         1'b1, 32'h0000_0007};
    tbl[12] = '{1'b0, 32'h0000_0028,    32'h0,         1'b1, 32'h0000_0000};
    tbl[13] = '{1'b0, 32'h0000_0040,    32'h0,         1'b1, 32'h0000_0000};
    tbl[14] = '{1'b0, 32'h1000_0024,    32'h0,         1'b1, 32'h0000_0000};
    tbl[15] = '{1'b1, 32'h0000_0040,    32'hFFFF_FFFF, 1'b0, 32'h0};
    tbl[16] = '{1'b1, 32'h1000_0024,    32'h0000_0000, 1'b0, 32'h0};
    tbl[17] = '{1'b1, 32'h0000_0028,    32'h0000_0000, 1'b0, 32'h0};
    tbl[18] = '{1'b0, ra(IDX_CTRL),     32'h0,         1'b1, 32'h0000_000D};
    tbl[19] = '{1'b0, ra(IDX_SCRATCH),  32'h0,         1'b1, 32'hDEAD_BEEF};
    tbl[20] = '{1'b0, ra(IDX_ISET),     32'h0,         1'b1, 32'h0000_1234};
    tbl[21] = '{1'b0, ra(IDX_STATUS),   32'h0,         1'b1, 32'h0000_0000};
    tbl[22] = '{1'b0, ra(IDX_IRQ_STAT), 32'h0,         1'b1, 32'h0000_0000};

    bus.reg_en = 1'b0; bus.reg_we = 1'b0; bus.reg_addr = '0; bus.reg_din = '0;
    repeat (3) @(negedge reg_clk);
    reg_rst = 1'b0;
    @(negedge reg_clk);

    check("rst_dout", bus.reg_dout, 32'h0);
    check("rst_outs", {charge_en, chg_mode, irq}, 32'h0);
    check("rst_sets", {iset, vset}, 32'h0);

    for (int i = 0; i < int'(NVEC); i++) begin
      access(tbl[i].we, tbl[i].addr, tbl[i].din);
      if (tbl[i].chk) check($sformatf("vec%0d", i), bus.reg_dout, tbl[i].exp);
    end
    check("out_ctrl", {30'h0, charge_en, chg_mode[1]} | {31'h0, chg_mode[0]}, 32'h3);
    check("out_mode", 32'(chg_mode), 32'h3);
    check("out_iset", 32'(iset), 32'h1234);
    check("out_vset", 32'(vset), 32'h0800);

    // Fault rise -> IRQ_STAT, irq one cycle later; W1C; set beats W1C
    chg_fault = 1'b1;
    @(negedge reg_clk);
    check("irq_lag", 32'(irq), 32'h0);
    @(negedge reg_clk);
    check("irq_fault", 32'(irq), 32'h1);
    rd_chk("status_fault", ra(IDX_STATUS), 32'h2);
    rd_chk("stat_fault", ra(IDX_IRQ_STAT), 32'h1);
    wr(ra(IDX_IRQ_STAT), 32'h1);
    @(negedge reg_clk);
    check("irq_cleared", 32'(irq), 32'h0);
    rd_chk("stat_w1c", ra(IDX_IRQ_STAT), 32'h0);
    chg_fault = 1'b0;
    @(negedge reg_clk);
    chg_fault = 1'b1;
    wr(ra(IDX_IRQ_STAT), 32'h1);
    rd_chk("stat_set_wins", ra(IDX_IRQ_STAT), 32'h1);
    chg_fault = 1'b0;
    wr(ra(IDX_IRQ_STAT), 32'h7);
    rd_chk("stat_clr_all", ra(IDX_IRQ_STAT), 32'h0);

    // OVP strictly greater than vset[11:0]
    adc_valid = 1'b1; adc_v = 12'h801; adc_i = 12'h123;
    @(negedge reg_clk);
    adc_valid = 1'b0;
    rd_chk("adc_v_ovp", ra(IDX_ADC_V), 32'h801);
    rd_chk("adc_i", ra(IDX_ADC_I), 32'h123);
    rd_chk("stat_ovp", ra(IDX_IRQ_STAT), 32'h4);
    wr(ra(IDX_IRQ_STAT), 32'h4);
    adc_valid = 1'b1; adc_v = 12'h800; adc_i = 12'h456;
    @(negedge reg_clk);
    adc_valid = 1'b0; adc_v = 12'hFFF;
    @(negedge reg_clk);
    rd_chk("adc_v_eq", ra(IDX_ADC_V), 32'h800);
    rd_chk("stat_no_ovp", ra(IDX_IRQ_STAT), 32'h0);

    // Full rise, then masking via IRQ_EN
    chg_full = 1'b1;
    @(negedge reg_clk);
    rd_chk("stat_full", ra(IDX_IRQ_STAT), 32'h2);
    rd_chk("status_full", ra(IDX_STATUS), 32'h4);
    check("irq_full", 32'(irq), 32'h1);
    wr(ra(IDX_IRQ_EN), 32'h0);
    @(negedge reg_clk);
    check("irq_masked", 32'(irq), 32'h0);
    chg_full = 1'b0;
    wr(ra(IDX_IRQ_STAT), 32'h7);

    // Session counting, clear, saturation, clear vs increment
    repeat (3) begin
      chg_active = 1'b1; @(negedge reg_clk);
      chg_active = 1'b0; @(negedge reg_clk);
    end
    rd_chk("sessions3", ra(IDX_SESSIONS), 32'h3);
    wr(ra(IDX_CTRL), 32'h0000_000F);
    rd_chk("sessions_clr", ra(IDX_SESSIONS), 32'h0);
    rd_chk("ctrl_after_clr", ra(IDX_CTRL), 32'hD);
    force dut.sessions = 32'hFFFF_FFFE;
    @(negedge reg_clk);
    release dut.sessions;
    repeat (2) begin
      chg_active = 1'b1; @(negedge reg_clk);
      chg_active = 1'b0; @(negedge reg_clk);
    end
    rd_chk("sessions_sat", ra(IDX_SESSIONS), 32'hFFFF_FFFF);
    chg_active = 1'b1;
    wr(ra(IDX_CTRL), 32'h0000_0002);
    chg_active = 1'b0;
    rd_chk("sessions_clr_wins", ra(IDX_SESSIONS), 32'h0);

    // Async reset during a pending write
    rd_chk("pre_rst_scratch", ra(IDX_SCRATCH), 32'hDEAD_BEEF);
    bus.reg_en = 1'b1; bus.reg_we = 1'b1;
    bus.reg_addr = ra(IDX_ISET); bus.reg_din = 32'h5555;
    #2 reg_rst = 1'b1;
    @(posedge reg_clk);
    #1;
    check("mid_rst_dout", bus.reg_dout, 32'h0);
    check("mid_rst_iset", 32'(iset), 32'h0);
    check("mid_rst_vset", 32'(vset), 32'h0);
    check("mid_rst_ctl", {29'h0, charge_en, chg_mode}, 32'h0);
    check("mid_rst_irq", 32'(irq), 32'h0);
    @(negedge reg_clk);
    bus.reg_en = 1'b0; bus.reg_we = 1'b0;
    reg_rst = 1'b0;
    @(negedge reg_clk);
    rd_chk("post_rst_iset", ra(IDX_ISET), 32'h0);
    rd_chk("post_rst_scratch", ra(IDX_SCRATCH), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
